autoplay_sequencer: RTL and testbench

Song sequencer for the piano's auto-play mode. Walks a song ROM note by note and drives the one-hot key / pitch inputs of the keyboard tone generator with timed durations and articulation gaps. Handles prev / pause / next buttons and exposes song and note indices for the seven-segment display. Sits between the top-level mode/button inputs and the keyboard block; the top muxes its key/pitch outputs against the manual switches.

---
 rtl/autoplay_sequencer_pkg.sv | 56 +++++
 rtl/autoplay_sequencer_if.sv | 10 +
 rtl/autoplay_sequencer_note_timer.sv | 46 ++++
 rtl/autoplay_sequencer.sv | 179 +++++++++++++++++
 tb/tb_autoplay_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/autoplay_sequencer_pkg.sv
// Shared types and constants for the auto-play song sequencer (package piano_pkg).
// Song ROM word layout, key/pitch codes, per-song base addresses and the key decoder.
package piano_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_PLAY   = 3'd3,
    ST_GAP    = 3'd4,
    ST_PAUSED = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam logic [2:0] KEY_REST = 3'd0;
  localparam logic [2:0] KEY_DO   = 3'd1;
  localparam logic [2:0] KEY_RE   = 3'd2;
  localparam logic [2:0] KEY_MI   = 3'd3;
  localparam logic [2:0] KEY_FA   = 3'd4;
  localparam logic [2:0] KEY_SOL  = 3'd5;
  localparam logic [2:0] KEY_LA   = 3'd6;
  localparam logic [2:0] KEY_SI   = 3'd7;

  localparam logic [1:0] PITCH_LOW  = 2'd0;
  localparam logic [1:0] PITCH_MID  = 2'd1;
  localparam logic [1:0] PITCH_HIGH = 2'd2;

  localparam int unsigned ROM_W     = 9;
  localparam int unsigned KEY_LSB   = 0;
  localparam int unsigned KEY_W     = 3;
  localparam int unsigned PITCH_LSB = 3;
  localparam int unsigned PITCH_W   = 2;
  localparam int unsigned BEATS_LSB = 5;
  localparam int unsigned BEATS_W   = 3;
  localparam int unsigned END_BIT   = 8;
  localparam int unsigned KEYS_N    = 7;
  localparam int unsigned SONG_W    = 2;
  localparam int unsigned MAX_SONGS = 4;

  localparam logic [7:0] SONG_BASE [MAX_SONGS] = '{8'h00, 8'h40, 8'h80, 8'hC0};

  // Rest (code 0) decodes to silence.
  function automatic logic [KEYS_N-1:0] key_onehot(input logic [KEY_W-1:0] code);
    case (code)
      KEY_DO:  key_onehot = 7'b000_0001;
      KEY_RE:  key_onehot = 7'b000_0010;
      KEY_MI:  key_onehot = 7'b000_0100;
      KEY_FA:  key_onehot = 7'b000_1000;
      KEY_SOL: key_onehot = 7'b001_0000;
      KEY_LA:  key_onehot = 7'b010_0000;
      KEY_SI:  key_onehot = 7'b100_0000;
      default: key_onehot = 7'b000_0000;
    endcase
  endfunction

endpackage

// File: rtl/autoplay_sequencer_if.sv
// Song ROM port: the sequencer drives the address, the ROM returns the word one cycle later.
interface autoplay_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0]          rom_addr;
  logic [piano_pkg::ROM_W-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/autoplay_sequencer_note_timer.sv
// Beat/tick down-counter pair timing one note or one articulation gap.
module note_timer
  import piano_pkg::*;
#(
  parameter int unsigned TICKS_PER_BEAT = 25_000_000,
  parameter int unsigned GAP_TICKS      = 2_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load_note,
  input  logic               i_load_gap,
  input  logic               i_run,
  input  logic [BEATS_W-1:0] i_beats_m1,
  output logic               o_expire_c
);

  localparam int unsigned MAX_TICKS = (TICKS_PER_BEAT > GAP_TICKS) ? TICKS_PER_BEAT : GAP_TICKS;
  localparam int unsigned TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  logic [TICK_W-1:0]  r_tick;
  logic [BEATS_W-1:0] r_beat;

  assign o_expire_c = (r_tick == '0) && (r_beat == '0);

  // Loads take priority; an expired pair holds at zero until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_beat <= '0;
    end else if (i_load_note) begin
      r_tick <= TICK_W'(TICKS_PER_BEAT - 1);
      r_beat <= i_beats_m1;
    end else if (i_load_gap) begin
      r_tick <= TICK_W'(GAP_TICKS - 1);
      r_beat <= '0;
    end else if (i_run && !o_expire_c) begin
      if (r_tick == '0) begin
        r_tick <= TICK_W'(TICKS_PER_BEAT - 1);
        r_beat <= r_beat - BEATS_W'(1);
      end else begin
        r_tick <= r_tick - TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/autoplay_sequencer.sv
// Auto-play song sequencer: walks the song ROM and drives timed key/pitch to the keyboard.
// Build option AUTOPLAY_LOOP_EN: the end marker restarts the current song instead of stopping.
module autoplay_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned TICKS_PER_BEAT = 25_000_000,
  parameter int unsigned GAP_TICKS      = 2_000_000,
  parameter int unsigned SONG_NUM       = 3,
  parameter int unsigned ADDR_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 btn_prev,
  input  logic                 btn_pause,
  input  logic                 btn_next,
  autoplay_sequencer_if.master rom,
  output logic [KEYS_N-1:0]    key_out,
  output logic [PITCH_W-1:0]   pitch_out,
  output logic [SONG_W-1:0]    song_idx,
  output logic [ADDR_W-1:0]    note_idx,
  output logic                 paused,
  output logic                 done
);

  state_t              r_state, r_saved;
  logic [KEYS_N-1:0]   r_key_out, r_key_latch;
  logic [PITCH_W-1:0]  r_pitch;
  logic [SONG_W-1:0]   r_song;
  logic [ADDR_W-1:0]   r_note, r_rom_addr;
  logic                r_paused, r_done;
  logic                r_prev_d, r_pause_d, r_next_d;

  state_t              w_state_nxt, w_saved_nxt;
  logic [KEYS_N-1:0]   w_key_nxt, w_latch_nxt;
  logic [PITCH_W-1:0]  w_pitch_nxt;
  logic [SONG_W-1:0]   w_song_nxt, w_song_inc, w_song_dec;
  logic [ADDR_W-1:0]   w_note_nxt, w_rom_addr_nxt;
  logic                w_prev_edge, w_pause_edge, w_next_edge, w_nav;
  logic                w_load_note, w_load_gap, w_run, w_expire;

  assign w_prev_edge  = btn_prev  & ~r_prev_d;
  assign w_pause_edge = btn_pause & ~r_pause_d;
  assign w_next_edge  = btn_next  & ~r_next_d;
  assign w_nav        = w_prev_edge ^ w_next_edge;
  assign w_run        = (r_state == ST_PLAY) || (r_state == ST_GAP);
  assign w_song_inc   = (r_song == SONG_W'(SONG_NUM - 1)) ? '0 : r_song + SONG_W'(1);
  assign w_song_dec   = (r_song == '0) ? SONG_W'(SONG_NUM - 1) : r_song - SONG_W'(1);

  note_timer #(
    .TICKS_PER_BEAT (TICKS_PER_BEAT),
    .GAP_TICKS      (GAP_TICKS)
  ) u_note_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load_note (w_load_note),
    .i_load_gap  (w_load_gap),
    .i_run       (w_run),
    .i_beats_m1  (rom.rom_data[BEATS_LSB +: BEATS_W]),
    .o_expire_c  (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_saved     <= ST_IDLE;
      r_key_out   <= '0;
      r_key_latch <= '0;
      r_pitch     <= PITCH_LOW;
      r_song      <= '0;
      r_note      <= '0;
      r_paused    <= 1'b0;
      r_done      <= 1'b0;
      r_rom_addr  <= ADDR_W'(SONG_BASE[0]);
      r_prev_d    <= 1'b0;
      r_pause_d   <= 1'b0;
      r_next_d    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_saved     <= w_saved_nxt;
      r_key_out   <= w_key_nxt;
      r_key_latch <= w_latch_nxt;
      r_pitch     <= w_pitch_nxt;
      r_song      <= w_song_nxt;
      r_note      <= w_note_nxt;
      r_paused    <= (w_state_nxt == ST_PAUSED);
      r_done      <= (w_state_nxt == ST_DONE);
      r_rom_addr  <= w_rom_addr_nxt;
      r_prev_d    <= btn_prev;
      r_pause_d   <= btn_pause;
      r_next_d    <= btn_next;
    end
  end

  // Normal progression first, then pause, navigation and enable override in rising priority.
  always_comb begin
    w_state_nxt = r_state;
    w_saved_nxt = r_saved;
    w_key_nxt   = r_key_out;
    w_latch_nxt = r_key_latch;
    w_pitch_nxt = r_pitch;
    w_song_nxt  = r_song;
    w_note_nxt  = r_note;
    w_load_note = 1'b0;
    w_load_gap  = 1'b0;

    case (r_state)
      ST_IDLE:  w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (rom.rom_data[END_BIT]) begin
`ifdef AUTOPLAY_LOOP_EN
          w_note_nxt  = '0;
          w_state_nxt = ST_FETCH;
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_latch_nxt = key_onehot(rom.rom_data[KEY_LSB +: KEY_W]);
          w_key_nxt   = key_onehot(rom.rom_data[KEY_LSB +: KEY_W]);
          w_pitch_nxt = rom.rom_data[PITCH_LSB +: PITCH_W];
          w_load_note = 1'b1;
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (w_expire) begin
          w_load_gap  = 1'b1;
          w_key_nxt   = '0;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_expire) begin
          w_note_nxt  = r_note + ADDR_W'(1);
          w_state_nxt = ST_FETCH;
        end
      end
      ST_PAUSED: begin
        if (w_pause_edge) begin
          w_state_nxt = r_saved;
          w_key_nxt   = (r_saved == ST_PLAY) ? r_key_latch : '0;
        end
      end
      default: w_state_nxt = r_state;
    endcase

    // Saving the already-advanced state lets a pause on an expiring cycle resume cleanly.
    if (w_pause_edge && w_run) begin
      w_saved_nxt = w_state_nxt;
      w_state_nxt = ST_PAUSED;
      w_key_nxt   = '0;
    end

    if (w_nav && (r_state != ST_IDLE)) begin
      w_song_nxt  = w_next_edge ? w_song_inc : w_song_dec;
      w_note_nxt  = '0;
      w_key_nxt   = '0;
      w_state_nxt = ST_FETCH;
    end

    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_key_nxt   = '0;
      w_note_nxt  = '0;
    end

    w_rom_addr_nxt = ADDR_W'(SONG_BASE[w_song_nxt]) + w_note_nxt;
  end

  assign rom.rom_addr = r_rom_addr;
  assign key_out      = r_key_out;
  assign pitch_out    = r_pitch;
  assign song_idx     = r_song;
  assign note_idx     = r_note;
  assign paused       = r_paused;
  assign done         = r_done;

endmodule

// File: tb/tb_autoplay_sequencer.sv
// Directed bench for autoplay_sequencer with short beat/gap timing and a three-song ROM model.
module tb_autoplay_sequencer;
  import piano_pkg::*;

  logic clk = 1'b0;
  logic rst_n, enable, btn_prev, btn_pause, btn_next;
  logic [6:0] key_out;
  logic [1:0] pitch_out, song_idx;
  logic [7:0] note_idx;
  logic       paused, done;
  logic [8:0] rom_mem [256];
  int n_chk = 0;
  int n_pass = 0;

  autoplay_sequencer_if #(.ADDR_W(8)) rom_if ();

  autoplay_sequencer #(
    .TICKS_PER_BEAT (4),
    .GAP_TICKS      (2),
    .SONG_NUM       (3),
    .ADDR_W         (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .btn_prev  (btn_prev),
    .btn_pause (btn_pause),
    .btn_next  (btn_next),
    .rom       (rom_if),
    .key_out   (key_out),
    .pitch_out (pitch_out),
    .song_idx  (song_idx),
    .note_idx  (note_idx),
    .paused    (paused),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; btn_prev = 1'b0; btn_pause = 1'b0; btn_next = 1'b0;
    repeat (2) tick();
    n_chk++; if (key_out !== 7'h00) $display("FAIL rst_key: got %h want 00", key_out); else n_pass++;
    n_chk++; if (pitch_out !== 2'd0) $display("FAIL rst_pitch: got %0d want 0", pitch_out); else n_pass++;
    n_chk++; if (song_idx !== 2'd0) $display("FAIL rst_song: got %0d want 0", song_idx); else n_pass++;
    n_chk++; if (note_idx !== 8'd0) $display("FAIL rst_note: got %0d want 0", note_idx); else n_pass++;
    n_chk++; if ({paused, done} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {paused, done}); else n_pass++;
    n_chk++; if (rom_if.rom_addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", rom_if.rom_addr); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_play_song();
    int n_hi = 0, bad = 0, first_hi = -1, last_hi = -1, done_at = -1;
    logic [7:0] addr23 = 8'hxx;
    enable = 1'b1;
    tick();
    n_chk++; if (rom_if.rom_addr !== 8'h00) $display("FAIL play_addr_c1: got %h want 00", rom_if.rom_addr); else n_pass++;
    for (int c = 2; c <= 40; c++) begin
      tick();
      if (c == 23) addr23 = rom_if.rom_addr;
      if (key_out !== 7'h00) begin
        n_hi++;
        last_hi = c;
        if (first_hi < 0) first_hi = c;
        if (key_out !== 7'h01 || pitch_out !== 2'd1) bad++;
      end
      if (done === 1'b1 && done_at < 0) done_at = c;
    end
    n_chk++; if (first_hi !== 3) $display("FAIL play_first_key: got %0d want 3", first_hi); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL play_key_value: got %0d bad cycles want 0", bad); else n_pass++;
`ifdef AUTOPLAY_LOOP_EN
    n_chk++; if (n_hi !== 16) $display("FAIL loop_key_cycles: got %0d want 16", n_hi); else n_pass++;
    n_chk++; if (last_hi !== 32) $display("FAIL loop_last_key: got %0d want 32", last_hi); else n_pass++;
    n_chk++; if (done_at !== -1) $display("FAIL loop_done: got %0d want -1", done_at); else n_pass++;
    n_chk++; if (addr23 !== 8'h00) $display("FAIL loop_addr: got %h want 00", addr23); else n_pass++;
`else
    n_chk++; if (n_hi !== 8) $display("FAIL play_key_cycles: got %0d want 8", n_hi); else n_pass++;
    n_chk++; if (last_hi !== 10) $display("FAIL play_last_key: got %0d want 10", last_hi); else n_pass++;
    n_chk++; if (done_at !== 23) $display("FAIL play_done_at: got %0d want 23", done_at); else n_pass++;
    n_chk++; if (addr23 !== 8'h02) $display("FAIL play_end_addr: got %h want 02", addr23); else n_pass++;
    btn_pause = 1'b1;
    tick();
    n_chk++; if ({paused, done} !== 2'b01) $display("FAIL done_pause_ignored: got %b want 01", {paused, done}); else n_pass++;
    btn_pause = 1'b0;
    tick();
`endif
  endtask

  task automatic test_pause();
    int n_hi = 0;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (key_out === 7'h01) n_hi++;
    end
    btn_pause = 1'b1;
    tick();
    n_chk++; if ({paused, key_out} !== {1'b1, 7'h00}) $display("FAIL pause_enter: got %b/%h want 1/00", paused, key_out); else n_pass++;
    repeat (3) tick();
    n_chk++; if ({paused, key_out} !== {1'b1, 7'h00}) $display("FAIL pause_hold: got %b/%h want 1/00", paused, key_out); else n_pass++;
    btn_pause = 1'b0;
    tick();
    btn_pause = 1'b1;
    tick();
    n_chk++; if ({paused, key_out} !== {1'b0, 7'h01}) $display("FAIL pause_resume: got %b/%h want 0/01", paused, key_out); else n_pass++;
    if (key_out === 7'h01) n_hi++;
    btn_pause = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (key_out === 7'h01) n_hi++;
    end
    n_chk++; if (n_hi !== 8) $display("FAIL pause_total_key: got %0d want 8", n_hi); else n_pass++;
`ifndef AUTOPLAY_LOOP_EN
    repeat (8) tick();
    n_chk++; if (done !== 1'b1) $display("FAIL pause_then_done: got %b want 1", done); else n_pass++;
`endif
  endtask

  task automatic test_next();
    btn_next = 1'b1;
    tick();
    n_chk++; if ({song_idx, note_idx, rom_if.rom_addr} !== {2'd1, 8'd0, 8'h40}) $display("FAIL next_to_1: got %0d/%0d/%h want 1/0/40", song_idx, note_idx, rom_if.rom_addr); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL next_clears_done: got %b want 0", done); else n_pass++;
    repeat (2) tick();
    n_chk++; if ({song_idx, key_out, pitch_out} !== {2'd1, 7'h02, 2'd2}) $display("FAIL next_held_play: got %0d/%h/%0d want 1/02/2", song_idx, key_out, pitch_out); else n_pass++;
    btn_next = 1'b0;
    tick();
    btn_next = 1'b1;
    tick();
    n_chk++; if ({song_idx, rom_if.rom_addr} !== {2'd2, 8'h80}) $display("FAIL next_to_2: got %0d/%h want 2/80", song_idx, rom_if.rom_addr); else n_pass++;
    btn_next = 1'b0;
    tick();
    btn_next = 1'b1;
    tick();
    n_chk++; if ({song_idx, note_idx, rom_if.rom_addr} !== {2'd0, 8'd0, 8'h00}) $display("FAIL next_wrap: got %0d/%0d/%h want 0/0/00", song_idx, note_idx, rom_if.rom_addr); else n_pass++;
    btn_next = 1'b0;
  endtask

  task automatic test_prev();
    btn_prev = 1'b1;
    tick();
    n_chk++; if ({song_idx, rom_if.rom_addr} !== {2'd2, 8'h80}) $display("FAIL prev_wrap: got %0d/%h want 2/80", song_idx, rom_if.rom_addr); else n_pass++;
    btn_prev = 1'b0;
    repeat (2) tick();
    n_chk++; if ({key_out, pitch_out} !== {7'h04, 2'd0}) $display("FAIL prev_play_mi: got %h/%0d want 04/0", key_out, pitch_out); else n_pass++;
    btn_prev = 1'b1; btn_next = 1'b1;
    tick();
    n_chk++; if ({song_idx, key_out, rom_if.rom_addr} !== {2'd2, 7'h04, 8'h80}) $display("FAIL prev_next_ignored: got %0d/%h/%h want 2/04/80", song_idx, key_out, rom_if.rom_addr); else n_pass++;
    btn_prev = 1'b0; btn_next = 1'b0;
    tick();
    btn_prev = 1'b1; btn_pause = 1'b1;
    tick();
    n_chk++; if ({song_idx, paused, key_out} !== {2'd1, 1'b0, 7'h00}) $display("FAIL prev_beats_pause: got %0d/%b/%h want 1/0/00", song_idx, paused, key_out); else n_pass++;
    btn_prev = 1'b0; btn_pause = 1'b0;
    tick();
  endtask

  task automatic test_enable_drop();
    int waited = 0;
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    repeat (2) tick();
    n_chk++; if ({song_idx, key_out} !== {2'd2, 7'h04}) $display("FAIL drop_setup: got %0d/%h want 2/04", song_idx, key_out); else n_pass++;
    enable = 1'b0;
    tick();
    n_chk++; if ({key_out, song_idx, note_idx} !== {7'h00, 2'd2, 8'd0}) $display("FAIL drop_mid_note: got %h/%0d/%0d want 00/2/0", key_out, song_idx, note_idx); else n_pass++;
    tick();
    enable = 1'b1;
    tick();
    n_chk++; if (rom_if.rom_addr !== 8'h80) $display("FAIL reenable_addr: got %h want 80", rom_if.rom_addr); else n_pass++;
    repeat (2) tick();
    n_chk++; if (key_out !== 7'h04) $display("FAIL reenable_key: got %h want 04", key_out); else n_pass++;
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    while (note_idx !== 8'd1 && waited < 30) begin
      tick();
      waited++;
    end
    n_chk++; if (note_idx !== 8'd1) $display("FAIL reach_note1: got %0d want 1 (timeout)", note_idx); else n_pass++;
    tick();
    enable = 1'b0;
    tick();
    n_chk++; if ({note_idx, song_idx, key_out} !== {8'd0, 2'd0, 7'h00}) $display("FAIL drop_note_clear: got %0d/%0d/%h want 0/0/00", note_idx, song_idx, key_out); else n_pass++;
    enable = 1'b1;
    repeat (3) tick();
    n_chk++; if ({key_out, pitch_out} !== {7'h01, 2'd1}) $display("FAIL restart_note0: got %h/%0d want 01/1", key_out, pitch_out); else n_pass++;
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({key_out, done, paused} !== {7'h00, 1'b0, 1'b0}) $display("FAIL async_reset: got %h/%b/%b want 00/0/0", key_out, done, paused); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom_mem[a] = 9'h100;
    rom_mem[8'h00] = {1'b0, 3'd1, PITCH_MID,  KEY_DO};
    rom_mem[8'h01] = {1'b0, 3'd0, PITCH_MID,  KEY_REST};
    rom_mem[8'h40] = {1'b0, 3'd0, PITCH_HIGH, KEY_RE};
    rom_mem[8'h80] = {1'b0, 3'd0, PITCH_LOW,  KEY_MI};
    test_reset();
    test_play_song();
    test_pause();
    test_next();
    test_prev();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
